// File: rtl/lcd_cfah_emul_pkg.sv
// Shared widths and the capture-log entry type for the CFAH LCD bus emulator.
package lcd_cfah_emul_pkg;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned AC_W   = 7;
  localparam int unsigned BUSY_W = 8;
  localparam int unsigned CNT_W  = 16;

  typedef struct packed {
    logic              rs;
    logic [DATA_W-1:0] data;
  } lcd_entry_t;
endpackage

// File: rtl/lcd_cmd_log.sv
// Circular write-only log of captured bus writes; oldest entries are overwritten.
module lcd_cmd_log
  import lcd_cfah_emul_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  lcd_entry_t       wr_entry_i,
  output logic [PTR_W-1:0] wr_ptr_o,
  output logic [CNT_W-1:0] cmd_count_o
);

  lcd_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (wr_en_i) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end
  end

  // Contents survive reset; only the pointer and count are cleared.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_entry_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign wr_ptr_o    = wr_ptr_q;
  assign cmd_count_o = cnt_q;

endmodule

// File: rtl/lcd_cfah_emul.sv
// HD44780-style LCD bus partner: captures host writes, answers reads with status or a supplied byte.
module lcd_cfah_emul
  import lcd_cfah_emul_pkg::*;
#(
  parameter int unsigned G_RECEIVED_CMD_BUFFER_SIZE = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_rs,
  input  logic              i_rw,
  input  logic              i_en,
  inout  wire  [DATA_W-1:0] io_data,
  input  logic [BUSY_W-1:0] i_busy_flag_duration,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_wdata_sel,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rdata_val
);

  localparam int unsigned PTR_W = $clog2(G_RECEIVED_CMD_BUFFER_SIZE);

  logic              en_q, rs_q, rw_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rdata_val_q, rdata_val_d;
  logic [BUSY_W-1:0] busy_q, busy_d;
  logic [AC_W-1:0]   ac_q, ac_d;
  logic              wr_fall, busy, rd_oe;
  logic [DATA_W-1:0] rd_byte;
  logic [PTR_W-1:0]  log_wr_ptr_unused;
  logic [CNT_W-1:0]  log_count_unused;

  assign wr_fall = en_q & ~i_en & ~rw_q;
  assign busy    = (busy_q != '0);

  always_comb begin
    rdata_d     = rdata_q;
    rdata_val_d = 1'b0;
    ac_d        = ac_q;
    busy_d      = busy ? busy_q - 1'b1 : busy_q;
    if (wr_fall) begin
      rdata_d     = data_q;
      rdata_val_d = 1'b1;
      busy_d      = i_busy_flag_duration;
      if (rs_q) ac_d = ac_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q        <= 1'b0;
      rs_q        <= 1'b0;
      rw_q        <= 1'b0;
      data_q      <= '0;
      rdata_q     <= '0;
      rdata_val_q <= 1'b0;
      busy_q      <= '0;
      ac_q        <= '0;
    end else begin
      en_q        <= i_en;
      rs_q        <= i_rs;
      rw_q        <= i_rw;
      data_q      <= io_data;
      rdata_q     <= rdata_d;
      rdata_val_q <= rdata_val_d;
      busy_q      <= busy_d;
      ac_q        <= ac_d;
    end
  end

  lcd_cmd_log #(
    .DEPTH(G_RECEIVED_CMD_BUFFER_SIZE)
  ) u_log (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (wr_fall & ~rst),
    .wr_entry_i ('{rs: rs_q, data: data_q}),
    .wr_ptr_o   (log_wr_ptr_unused),
    .cmd_count_o(log_count_unused)
  );

  // Read drive follows the raw strobes so the bus is released in the same cycle.
  assign rd_oe   = i_en & i_rw;
  assign rd_byte = i_wdata_sel ? i_wdata : {busy, ac_q};
  assign io_data = rd_oe ? rd_byte : 'z;

  assign o_rdata     = rdata_q;
  assign o_rdata_val = rdata_val_q;

endmodule

// File: tb/tb_lcd_cfah_emul.sv
// Directed bench for lcd_cfah_emul: writes, status/bench-byte reads, log wrap and busy reload.
module tb_lcd_cfah_emul;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       i_rs = 1'b0, i_rw = 1'b0, i_en = 1'b0;
  logic [7:0] i_busy_flag_duration = '0;
  logic [7:0] i_wdata = '0;
  logic       i_wdata_sel = 1'b0;
  logic [7:0] o_rdata;
  logic       o_rdata_val;
  logic [7:0] tb_drv = '0;
  logic       tb_oe = 1'b0;
  wire  [7:0] io_data;
  int         pass = 0;
  int         total = 0;

  assign io_data = tb_oe ? tb_drv : 8'bz;

  always #5 clk = ~clk;

  lcd_cfah_emul #(.G_RECEIVED_CMD_BUFFER_SIZE(256)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_rs                (i_rs),
    .i_rw                (i_rw),
    .i_en                (i_en),
    .io_data             (io_data),
    .i_busy_flag_duration(i_busy_flag_duration),
    .i_wdata             (i_wdata),
    .i_wdata_sel         (i_wdata_sel),
    .o_rdata             (o_rdata),
    .o_rdata_val         (o_rdata_val)
  );

  task automatic do_reset();
    rst = 1'b1; i_en = 1'b0; i_rw = 1'b0; tb_oe = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  // Returns one cycle after the capturing edge, when o_rdata_val should be high.
  task automatic wr(input logic rs, input logic [7:0] d, input logic [7:0] dur);
    i_rs = rs; i_rw = 1'b0; tb_drv = d; tb_oe = 1'b1; i_busy_flag_duration = dur; i_en = 1'b1;
    @(posedge clk); #1;
    i_en = 1'b0;
    @(posedge clk); #1;
    tb_oe = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0;
    total++; if (o_rdata !== 8'h00) $display("FAIL reset_rdata got %h exp 00", o_rdata); else pass++;
    total++; if (o_rdata_val !== 1'b0) $display("FAIL reset_val got %b exp 0", o_rdata_val); else pass++;
    total++; if (dut.rd_oe !== 1'b0) $display("FAIL reset_io_z drive got %b exp 0", dut.rd_oe); else pass++;
    total++; if (dut.busy_q !== 8'h00) $display("FAIL reset_busy got %h exp 00", dut.busy_q); else pass++;
    // write whose falling edge lands on rst
    i_rs = 1'b1; i_rw = 1'b0; tb_drv = 8'h77; tb_oe = 1'b1; i_busy_flag_duration = 8'd5; i_en = 1'b1;
    @(posedge clk); #1;
    i_en = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; tb_oe = 1'b0;
    @(posedge clk); #1;
    total++; if (o_rdata_val !== 1'b0 || o_rdata !== 8'h00)
      $display("FAIL rst_discard got val=%b rdata=%h exp val=0 rdata=00", o_rdata_val, o_rdata); else pass++;
    total++; if (dut.u_log.cnt_q !== 16'd0) $display("FAIL rst_discard_cnt got %0d exp 0", dut.u_log.cnt_q); else pass++;
  endtask

  task automatic test_instr_busy();
    logic [7:0] exp;
    do_reset();
    wr(1'b0, 8'h38, 8'd10);
    total++; if (o_rdata_val !== 1'b1 || o_rdata !== 8'h38)
      $display("FAIL instr_capture got val=%b rdata=%h exp val=1 rdata=38", o_rdata_val, o_rdata); else pass++;
    i_rw = 1'b1; i_wdata_sel = 1'b0; i_en = 1'b1;
    #1;
    for (int k = 1; k <= 11; k++) begin
      exp = (k <= 10) ? 8'h80 : 8'h00;
      total++; if (io_data !== exp) $display("FAIL busy_status k=%0d got %h exp %h", k, io_data, exp); else pass++;
      if (k == 2) begin
        total++; if (o_rdata_val !== 1'b0) $display("FAIL instr_single_pulse got %b exp 0", o_rdata_val); else pass++;
      end
      @(posedge clk); #1;
    end
    i_en = 1'b0; i_rw = 1'b0;
    @(posedge clk); #1;
    total++; if (o_rdata_val !== 1'b0 || o_rdata !== 8'h38 || dut.u_log.cnt_q !== 16'd1)
      $display("FAIL read_no_state got val=%b rdata=%h cnt=%0d exp val=0 rdata=38 cnt=1",
               o_rdata_val, o_rdata, dut.u_log.cnt_q); else pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    wr(1'b1, 8'h41, 8'd2);
    total++; if (o_rdata_val !== 1'b1 || o_rdata !== 8'h41)
      $display("FAIL b2b_first got val=%b rdata=%h exp val=1 rdata=41", o_rdata_val, o_rdata); else pass++;
    wr(1'b1, 8'h42, 8'd2);
    total++; if (o_rdata_val !== 1'b1 || o_rdata !== 8'h42)
      $display("FAIL b2b_second got val=%b rdata=%h exp val=1 rdata=42", o_rdata_val, o_rdata); else pass++;
    repeat (3) begin @(posedge clk); #1; end
    i_rw = 1'b1; i_wdata_sel = 1'b0; i_en = 1'b1;
    #1;
    total++; if (io_data !== 8'h02) $display("FAIL b2b_status got %h exp 02", io_data); else pass++;
    @(posedge clk); #1;
    i_en = 1'b0; i_rw = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_wdata_sel();
    i_wdata = 8'hA5; i_wdata_sel = 1'b1; i_rw = 1'b1; i_en = 1'b1;
    #1;
    total++; if (io_data !== 8'hA5 || dut.rd_oe !== 1'b1)
      $display("FAIL sel_read got %h oe=%b exp a5 oe=1", io_data, dut.rd_oe); else pass++;
    @(posedge clk); #1;
    i_en = 1'b0;
    #1;
    total++; if (dut.rd_oe !== 1'b0) $display("FAIL sel_release got oe=%b exp 0", dut.rd_oe); else pass++;
    i_rw = 1'b0;
    @(posedge clk); #1;
    total++; if (o_rdata_val !== 1'b0 || o_rdata !== 8'h42)
      $display("FAIL sel_no_pulse got val=%b rdata=%h exp val=0 rdata=42", o_rdata_val, o_rdata); else pass++;
    i_wdata_sel = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    logic [8:0] e0, e1;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      wr(1'b1, 8'(i), 8'd0);
      if (i == 126) begin
        total++; if (dut.ac_q !== 7'd127) $display("FAIL ac_127 got %0d exp 127", dut.ac_q); else pass++;
      end
      if (i == 127) begin
        i_rw = 1'b1; i_en = 1'b1; #1;
        total++; if (io_data !== 8'h00) $display("FAIL ac_wrap_status got %h exp 00", io_data); else pass++;
        @(posedge clk); #1;
        i_en = 1'b0; i_rw = 1'b0;
        @(posedge clk); #1;
      end
    end
    wr(1'b0, 8'hC3, 8'd0);
    e0 = dut.u_log.mem_q[0];
    e1 = dut.u_log.mem_q[1];
    total++; if (dut.u_log.wr_ptr_q !== 8'd1) $display("FAIL wrap_ptr got %0d exp 1", dut.u_log.wr_ptr_q); else pass++;
    total++; if (dut.u_log.cnt_q !== 16'd257) $display("FAIL wrap_count got %0d exp 257", dut.u_log.cnt_q); else pass++;
    total++; if (e0 !== 9'h0C3) $display("FAIL wrap_log0 got %h exp 0c3", e0); else pass++;
    total++; if (e1 !== 9'h101) $display("FAIL wrap_log1 got %h exp 101", e1); else pass++;
  endtask

  task automatic test_reload_reset();
    logic [7:0] exp;
    do_reset();
    wr(1'b0, 8'h01, 8'd20);
    repeat (4) begin @(posedge clk); #1; end
    total++; if (dut.busy_q !== 8'd16) $display("FAIL busy_count got %0d exp 16", dut.busy_q); else pass++;
    wr(1'b0, 8'h02, 8'd3);
    i_rw = 1'b1; i_wdata_sel = 1'b0; i_en = 1'b1;
    #1;
    for (int k = 1; k <= 4; k++) begin
      exp = (k <= 3) ? 8'h80 : 8'h00;
      total++; if (io_data !== exp) $display("FAIL reload_status k=%0d got %h exp %h", k, io_data, exp); else pass++;
      @(posedge clk); #1;
    end
    i_en = 1'b0; i_rw = 1'b0;
    @(posedge clk); #1;
    wr(1'b1, 8'h03, 8'd20);
    @(posedge clk); #1;
    total++; if (dut.busy_q !== 8'd19 || dut.ac_q !== 7'd1)
      $display("FAIL pre_rst got busy=%0d ac=%0d exp busy=19 ac=1", dut.busy_q, dut.ac_q); else pass++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (dut.busy_q !== 8'd0 || dut.ac_q !== 7'd0)
      $display("FAIL mid_busy_rst got busy=%0d ac=%0d exp 0 0", dut.busy_q, dut.ac_q); else pass++;
    i_rw = 1'b1; i_en = 1'b1; #1;
    total++; if (io_data !== 8'h00) $display("FAIL post_rst_status got %h exp 00", io_data); else pass++;
    @(posedge clk); #1;
    i_en = 1'b0; i_rw = 1'b0;
  endtask

  initial begin
    test_reset();
    test_instr_busy();
    test_back_to_back();
    test_wdata_sel();
    test_wrap();
    test_reload_reset();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
